uart_bus_ctrl: RTL
==================

# uart_bus_ctrl

Memory-mapped controller between the single-cycle RISC-V core's data bus and the UART transmit/receive engines. It buffers outgoing bytes in a small TX FIFO and sequences them into the TX engine over a start/busy handshake. It holds the last received byte with parity and overrun status, and raises a level interrupt to the core. The UART engines themselves (8 data bits, even parity, 1 stop, 5208 clk/bit at 50 MHz) are outside this block.

## Interface
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, 2..16.
- `BUSY_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after a launch.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on the `clk` rising edge.
- `mem_addr` in 4: byte offset within the block. 0x0 TXDATA, 0x4 RXDATA, 0x8 STATUS, 0xC CTRL.
- `mem_we` in 1: bus write strobe, one access per cycle.
- `mem_re` in 1: bus read strobe.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data. Combinational from `mem_addr` when `mem_re`=1, otherwise 0.
- `tx_start` out 1: one-cycle launch pulse to the TX engine.
- `tx_data` out 8: byte to send. Valid while `tx_start`=1.
- `tx_busy` in 1: TX engine is shifting.
- `rx_valid` in 1: one-cycle pulse, a received byte is available.
- `rx_data` in 8: received byte, valid with `rx_valid`.
- `rx_parity_err` in 1: parity mismatch on the byte, valid with `rx_valid`.
- `irq` out 1: level interrupt to the core.

## Operation
- **TXDATA write:** pushes `mem_wdata[7:0]`.
  - FIFO full: the byte is dropped and sticky `tx_ovf` is set.
  - Full FIFO with a pop in the same cycle: the push is accepted.
- **RXDATA read:** returns `{24'b0, rx_byte}`. At the clock edge it clears `rx_full`.
- **STATUS read bits:**
  - [0] fifo_full
  - [1] fifo_empty
  - [2] tx_active (FSM not IDLE or FIFO non-empty)
  - [3] rx_full
  - [4] rx_ovr
  - [5] par_err
  - [6] tx_done
  - [7] tx_ovf
  - [12:8] fifo_count
  - other bits 0
- **STATUS write:** write-1-to-clear on bits 4..7. Other bits are ignored.
- **CTRL (read/write):** [0] rx_ie, [1] tx_ie. Other bits read 0.
- **Unmapped addresses:** reads return 0, writes are ignored.
- **RX capture on `rx_valid`:**
  - `rx_full`=0: latch `rx_data` and set `rx_full`.
  - `rx_full`=1 with no RXDATA read in the same cycle: keep the old byte, drop the new one, set `rx_ovr`.
  - `rx_valid` together with an RXDATA read: the new byte is latched, `rx_full` stays 1, no overrun.
  - `rx_parity_err`=1: set `par_err`. The byte is still captured under the rules above.
- **`irq`** = `(rx_ie & (rx_full | rx_ovr | par_err)) | (tx_ie & tx_done)`.
- **TX FSM:**
  - IDLE → LAUNCH when the FIFO is non-empty and `tx_busy`=0.
  - LAUNCH: `tx_start`=1, `tx_data`=FIFO head, pop. Always goes to WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when `tx_busy`=1. Falls back to IDLE after `BUSY_TIMEOUT` cycles without busy; the byte counts as sent.
  - WAIT_DONE → IDLE when `tx_busy`=0. If the FIFO is then empty, set `tx_done`.
- **Reset values:**
  - FIFO empty; FSM IDLE; all flags and CTRL bits 0.
  - Outputs: `tx_start`=0, `tx_data`=0, `irq`=0, `mem_rdata`=0.
  - Reset in mid-frame discards queued bytes. It does not wait for the engine to finish.

## Timing
- Reads have zero latency. Side effects and writes take effect at the edge ending the access cycle.
- TXDATA write in cycle N with the FSM IDLE and `tx_busy`=0: `tx_start` is high in cycle N+2 for exactly one cycle; `fifo_count` drops in N+3.
- Back-to-back queued bytes: the next `tx_start` comes 2 cycles after `tx_busy` falls.
- `rx_valid` in cycle N: `rx_full` and `irq` (if `rx_ie`=1) are high from N+1.
- `irq` is registered-flag-derived and carries no combinational path from the bus.

## Structure
- Package `uart_bus_ctrl_pkg` holds:
  - register offset constants
  - STATUS/CTRL bit-position constants
  - the FSM state typedef (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE)
- Sub-module `uart_ctrl_fifo`: synchronous FIFO with `FIFO_DEPTH` entries.
  - Ports: push, pop, head, count, full, empty.
  - Behaviour: wrap-around pointers; simultaneous push and pop when full is allowed.
- The FSM, RX holding register and register file stay in the top module.

## Test plan
- **Single byte:** reset low 2 cycles; write 0x06 to TXDATA → `tx_start` pulses in cycle N+2 with `tx_data`=0x06. The engine model holds busy for 5208×11 clocks; afterwards `tx_done`=1, and `irq`=1 with `tx_ie` set.
- **FIFO overflow:** write 0x01..0x06 while `tx_busy` is held high → `fifo_count`=4, `tx_ovf`=1. Bytes 0x01..0x04 go out in order; W1C 0x80 clears `tx_ovf`.
- **RX path:** pulse `rx_valid` with 0x06, `rx_parity_err`=0 → STATUS[3]=1. RXDATA read returns 0x00000006 and the next STATUS read has bit3=0.
- **RX overrun and parity:** two `rx_valid` pulses (0x0A, then 0x0B with `rx_parity_err`=1) and no read → RXDATA=0x0A, `rx_ovr`=1, `par_err`=1. W1C 0x30 clears both.
- **Simultaneous RX:** RXDATA read in the same cycle as `rx_valid` with 0x0C → read returns the old byte, `rx_full`=1, the new byte is 0x0C, `rx_ovr`=0.
- **Busy timeout and reset:**
  - Launch with `tx_busy` never rising → FSM is back in IDLE after 4 cycles.
  - Reset asserted mid-WAIT_DONE with 3 bytes queued → next cycle: `fifo_count`=0, `tx_start`=0, `irq`=0.

Source files
------------

// File: rtl/uart_bus_ctrl_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX sequencer state type
// for the UART bus controller.
package uart_bus_ctrl_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_RXDATA = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int ST_FIFO_FULL  = 0;
    localparam int ST_FIFO_EMPTY = 1;
    localparam int ST_TX_ACTIVE  = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVR     = 4;
    localparam int ST_PAR_ERR    = 5;
    localparam int ST_TX_DONE    = 6;
    localparam int ST_TX_OVF     = 7;
    localparam int ST_COUNT_LSB  = 8;

    localparam int CTRL_RX_IE = 0;
    localparam int CTRL_TX_IE = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txState_e;

endpackage

// File: rtl/uart_ctrl_fifo.sv
// TX byte FIFO with wrap-around pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module uart_ctrl_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic              doPush;
    logic              doPop;

    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    // Storage is not reset; reset only empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: TX FIFO sequencing into the TX engine, RX
// holding register with overrun/parity status, control register and level irq.
//   state     | meaning
//   IDLE      | waiting for a queued byte and an idle TX engine
//   LAUNCH    | tx_start pulse with FIFO head, head popped
//   WAIT_BUSY | waiting for the engine to raise tx_busy (bounded by BUSY_TIMEOUT)
//   WAIT_DONE | engine shifting; back to IDLE when tx_busy drops
module uart_bus_ctrl
    import uart_bus_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_addr,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_parity_err,
    output logic        irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

    txState_e         txState;
    logic [TMR_W-1:0] busyTimer;
    logic [7:0]       fifoHead;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;
    logic             fifoPop;

    logic       txDataWrite;
    logic       statusWrite;
    logic       ctrlWrite;
    logic       rxRead;
    logic [7:0] stClr;
    logic       txDoneSet;
    logic       txOvfSet;

    logic [7:0] rxByte;
    logic       rxFull;
    logic       rxOvr;
    logic       parErr;
    logic       txDone;
    logic       txOvf;
    logic       rxIe;
    logic       txIe;
    logic       txActive;
    logic [31:0] statusWord;
    logic       unusedWdata;

    assign txDataWrite = mem_we && (mem_addr == ADDR_TXDATA);
    assign statusWrite = mem_we && (mem_addr == ADDR_STATUS);
    assign ctrlWrite   = mem_we && (mem_addr == ADDR_CTRL);
    assign rxRead      = mem_re && (mem_addr == ADDR_RXDATA);
    assign stClr       = statusWrite ? mem_wdata[7:0] : 8'h00;
    assign unusedWdata = ^mem_wdata[31:8];

    assign fifoPop  = (txState == LAUNCH);
    assign txOvfSet = txDataWrite && fifoFull && !fifoPop;

    // A byte given up on after the busy timeout still completes the queue.
    assign txDoneSet = fifoEmpty && !tx_busy &&
                       ((txState == WAIT_DONE) ||
                        ((txState == WAIT_BUSY) && (busyTimer == '0)));

    uart_ctrl_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (8)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (txDataWrite),
        .pushData (mem_wdata[7:0]),
        .pop      (fifoPop),
        .head     (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            txState   <= IDLE;
            busyTimer <= '0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (txState)
                IDLE: begin
                    if (!fifoEmpty && !tx_busy) begin
                        txState  <= LAUNCH;
                        tx_start <= 1'b1;
                        tx_data  <= fifoHead;
                    end
                end
                LAUNCH: begin
                    txState   <= WAIT_BUSY;
                    busyTimer <= TMR_W'(BUSY_TIMEOUT - 1);
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        txState <= WAIT_DONE;
                    end else if (busyTimer == '0) begin
                        txState <= IDLE;
                    end else begin
                        busyTimer <= busyTimer - 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        txState <= IDLE;
                    end
                end
                default: txState <= IDLE;
            endcase
        end
    end

    // Event sets win over a same-cycle write-1-to-clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxByte <= 8'h00;
            rxFull <= 1'b0;
            rxOvr  <= 1'b0;
            parErr <= 1'b0;
            txDone <= 1'b0;
            txOvf  <= 1'b0;
            rxIe   <= 1'b0;
            txIe   <= 1'b0;
        end else begin
            if (rx_valid && (!rxFull || rxRead)) begin
                rxByte <= rx_data;
            end
            rxFull <= rx_valid || (rxFull && !rxRead);
            rxOvr  <= (rxOvr  && !stClr[ST_RX_OVR])  || (rx_valid && rxFull && !rxRead);
            parErr <= (parErr && !stClr[ST_PAR_ERR]) || (rx_valid && rx_parity_err);
            txDone <= (txDone && !stClr[ST_TX_DONE]) || txDoneSet;
            txOvf  <= (txOvf  && !stClr[ST_TX_OVF])  || txOvfSet;
            if (ctrlWrite) begin
                rxIe <= mem_wdata[CTRL_RX_IE];
                txIe <= mem_wdata[CTRL_TX_IE];
            end
        end
    end

    assign txActive = (txState != IDLE) || !fifoEmpty;
    assign irq      = (rxIe && (rxFull || rxOvr || parErr)) || (txIe && txDone);

    always_comb begin
        statusWord                           = '0;
        statusWord[ST_FIFO_FULL]             = fifoFull;
        statusWord[ST_FIFO_EMPTY]            = fifoEmpty;
        statusWord[ST_TX_ACTIVE]             = txActive;
        statusWord[ST_RX_FULL]               = rxFull;
        statusWord[ST_RX_OVR]                = rxOvr;
        statusWord[ST_PAR_ERR]               = parErr;
        statusWord[ST_TX_DONE]               = txDone;
        statusWord[ST_TX_OVF]                = txOvf;
        statusWord[ST_COUNT_LSB +: CNT_W]    = fifoCount;
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re) begin
            case (mem_addr)
                ADDR_RXDATA: mem_rdata = {24'h0, rxByte};
                ADDR_STATUS: mem_rdata = statusWord;
                ADDR_CTRL:   mem_rdata = {30'h0, txIe, rxIe};
                default:     mem_rdata = '0;
            endcase
        end
    end

endmodule
